// File: rtl/dsp_pkg.sv
// dsp_pkg: shared DSP slice constants and the P result word type.
package dsp_pkg;
    localparam int P_WIDTH       = 48;
    localparam int DRAIN_LAT_MAX = 8;
    typedef logic [P_WIDTH-1:0] p_word_t;
endpackage

// File: rtl/dsp_sync_fifo.sv
// dsp_sync_fifo: synchronous FIFO holding drained {cout,P} results.
//  clk, rst_n : clock, async active-low reset (pointers only)
//  push/wdata : write an entry
//  pop/rdata  : consume head; rdata shows head, zero when empty
//  level      : occupancy 0..DEPTH
module dsp_sync_fifo #(
    parameter int WIDTH = 49,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wptr, rptr;
    logic empty, full, wr, rd;
    // The extra pointer MSB separates full (MSBs differ) from empty (MSBs equal).
    assign empty = wptr == rptr;
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign wr    = push & ~full;
    assign rd    = pop & ~empty;
    assign level = wptr - rptr;
    assign rdata = empty ? '0 : mem[rptr[AW-1:0]];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            wptr <= wptr + (AW+1)'(wr);
            rptr <= rptr + (AW+1)'(rd);
        end
    end
    always_ff @(posedge clk) begin
        if (wr) mem[wptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/dsp_result_drain.sv
// dsp_result_drain: drains DSP slice P/CARRYOUT results into a credit-protected valid/ready stream.
//  clk, rst_n          : clock, async active-low reset
//  clk_en              : slice clock enable; tag pipe advances only when high
//  issue / in_ready    : operand set issued to slice / issue credit available
//  p_in, cout_in       : slice outputs, captured when the issue's tag emerges
//  out_valid/out_ready : result stream handshake; out_data/out_cout show the head
//  level               : buffered result count
//  err                 : sticky, issue attempted without credit while enabled
module dsp_result_drain
    import dsp_pkg::*;
#(
    parameter int WIDTH = P_WIDTH,
    parameter int LAT   = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clk_en,
    input  logic                     issue,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         p_in,
    input  logic                     cout_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_cout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     err
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW:0] DEPTH_W = (LW+1)'(DEPTH);
    logic [LAT-1:0] tag;
    logic [LW-1:0]  inflight;
    logic           accept, push, pop;
    // Credits count both in-flight and buffered results, so a push can never find the FIFO full.
    assign in_ready  = ({1'b0, inflight} + {1'b0, level}) < DEPTH_W;
    assign accept    = issue & clk_en & in_ready;
    assign push      = clk_en & tag[LAT-1];
    assign out_valid = level != '0;
    assign pop       = out_valid & out_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag      <= '0;
            inflight <= '0;
            err      <= 1'b0;
        end else begin
            if (clk_en) begin
                for (int i = LAT-1; i > 0; i--) tag[i] <= tag[i-1];
                tag[0] <= accept;
            end
            inflight <= inflight + LW'(accept) - LW'(push);
            err      <= err | (issue & clk_en & ~in_ready);
        end
    end
    dsp_sync_fifo #(.WIDTH(WIDTH+1), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({cout_in, p_in}),
        .pop   (pop),
        .rdata ({out_cout, out_data}),
        .level (level)
    );
endmodule

// File: tb/tb_dsp_result_drain.sv
// tb_dsp_result_drain: randomized + directed scoreboard bench for dsp_result_drain.
module tb_dsp_result_drain;
    import dsp_pkg::*;
    localparam int LAT = 4, DEPTH = 4, LW = $clog2(DEPTH) + 1;
    logic clk = 0, rst_n = 0, clk_en = 0, issue = 0, cout_in = 0, out_ready = 0;
    p_word_t p_in = '0;
    logic in_ready, out_valid, out_cout, err;
    p_word_t out_data;
    logic [LW-1:0] level;
    always #5 clk = ~clk;
    dsp_result_drain #(.WIDTH(P_WIDTH), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .issue(issue), .in_ready(in_ready),
        .p_in(p_in), .cout_in(cout_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_cout(out_cout), .level(level), .err(err)
    );
    int checks = 0, errors = 0;
    typedef struct { p_word_t d; logic c; } res_t;
    res_t exp_q[$];
    res_t h;
    int age_q[$];
    int inf_m = 0, lvl_m = 0;
    bit err_m = 0, m_acc, m_push, m_pop, m_rdy, hold_p = 0;
    p_word_t p_fix = 48'h0000_1234_5678;
    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask
    // Reference model: each accepted issue waits LAT enabled edges, then the p_in seen at that edge is a result.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            age_q.delete();
            inf_m = 0;
            lvl_m = 0;
            err_m = 0;
        end else begin
            m_rdy  = (inf_m + lvl_m) < DEPTH;
            m_acc  = issue && clk_en && m_rdy;
            if (issue && clk_en && !m_rdy) err_m = 1;
            m_pop  = (lvl_m != 0) && out_ready;
            m_push = 0;
            if (clk_en) begin
                foreach (age_q[i]) age_q[i]--;
                if (age_q.size() > 0 && age_q[0] == 0) begin
                    m_push = 1;
                    void'(age_q.pop_front());
                    exp_q.push_back('{p_in, cout_in});
                end
            end
            if (m_acc) age_q.push_back(LAT);
            inf_m = inf_m + int'(m_acc) - int'(m_push);
            lvl_m = lvl_m + int'(m_push) - int'(m_pop);
        end
    end
    // Monitor: compares DUT outputs with the model mid-cycle and pops accepted results.
    always @(negedge clk) begin
        assert (inf_m + lvl_m <= DEPTH);
        chk("credit_bound", level <= DEPTH, 1);
        chk("out_valid", out_valid, lvl_m != 0);
        chk("level", level, lvl_m);
        chk("in_ready", in_ready, (inf_m + lvl_m) < DEPTH);
        chk("err", err, err_m);
        if (out_valid) begin
            if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
            else begin
                h = exp_q[0];
                chk("out_data", out_data, h.d);
                chk("out_cout", out_cout, h.c);
                if (out_ready) void'(exp_q.pop_front());
            end
        end else begin
            chk("empty_data", {out_cout, out_data}, 0);
        end
    end
    // i: 0/1 drive issue directly, 2 issue only when a credit is shown
    task automatic cyc(input int i, input bit e, input bit r);
        @(posedge clk);
        #1;
        clk_en    = e;
        out_ready = r;
        issue     = (i == 2) ? in_ready : i[0];
        p_in      = hold_p ? p_fix : p_word_t'({$urandom, $urandom});
        cout_in   = 1'($urandom_range(0, 1));
    endtask
    task automatic wait_level(input int n);
        for (int k = 0; k < 40 && level != LW'(n); k++) cyc(0, 1, 0);
        chk("wait_level", level, n);
    endtask
    int n;
    initial begin
        repeat (3) cyc(0, 0, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_level", level, 0);
        chk("rst_valid", out_valid, 0);
        rst_n = 1;
        // single issue latency and data
        hold_p = 1;
        cyc(1, 1, 0);
        repeat (LAT) cyc(0, 1, 0);
        @(negedge clk);
        chk("t1_not_yet", out_valid, 0);
        cyc(0, 1, 0);
        @(negedge clk);
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, 48'h0000_1234_5678);
        chk("t1_level", level, 1);
        hold_p = 0;
        repeat (3) cyc(0, 1, 1);
        // fill credits, overissue
        repeat (5) cyc(1, 1, 0);
        wait_level(4);
        repeat (3) cyc(0, 1, 0);
        @(negedge clk);
        chk("t2_level", level, 4);
        chk("t2_err", err, 1);
        repeat (8) cyc(0, 1, 1);
        // enable drop mid-flight
        cyc(1, 1, 1);
        cyc(1, 1, 1);
        repeat (3) cyc(0, 0, 1);
        repeat (10) cyc(0, 1, 1);
        // 20 issues with 1010 consumer
        n = 0;
        for (int k = 0; k < 300 && n < 20; k++) begin
            cyc(2, 1, k % 2 == 0);
            n += int'(issue);
        end
        chk("t4_issued", n, 20);
        repeat (20) cyc(0, 1, 1);
        // push and pop together at level 2
        repeat (3) cyc(1, 1, 0);
        wait_level(1);
        cyc(0, 1, 1);
        cyc(0, 1, 0);
        @(negedge clk);
        chk("t5_level", level, 2);
        repeat (6) cyc(0, 1, 1);
        // async reset with 1 buffered, 2 in flight
        repeat (3) cyc(1, 1, 0);
        wait_level(1);
        rst_n = 0;
        #1;
        chk("t6_valid", out_valid, 0);
        chk("t6_data", {out_cout, out_data}, 0);
        chk("t6_level", level, 0);
        chk("t6_err", err, 0);
        repeat (2) cyc(0, 1, 1);
        rst_n = 1;
        chk("t6_in_ready", in_ready, 1);
        repeat (12) cyc(0, 1, 1);
        // random traffic
        repeat (400) cyc(int'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
        repeat (20) cyc(0, 1, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
